// File: rtl/grid_pkg.sv
// grid_pkg: shared types, sizes and address helpers for the game-grid memory
package grid_pkg;
  localparam int GRID_W    = 15;
  localparam int GRID_H    = 15;
  localparam int NUM_CELLS = GRID_W * GRID_H;
  typedef logic [1:0] cell_t;
  typedef logic [3:0] coord_t;
  typedef logic [7:0] addr_t;
  localparam cell_t CELL_WORLD = 2'b00;
  localparam cell_t CELL_FOOD  = 2'b01;
  localparam cell_t CELL_SNAKE = 2'b10;
  localparam cell_t INIT_CELL  = CELL_WORLD;
  typedef enum logic {S_INIT, S_RUN} state_t;
  // Row-major cell index; only meaningful for in-grid coordinates
  function automatic addr_t cell_addr(coord_t x, coord_t y);
    return addr_t'(y) * addr_t'(GRID_W) + addr_t'(x);
  endfunction
  function automatic logic in_grid(coord_t x, coord_t y);
    return (x < coord_t'(GRID_W)) && (y < coord_t'(GRID_H));
  endfunction
endpackage

// File: rtl/grid_ram.sv
// grid_ram: single-port cell memory, clocked write with same-cycle read data
module grid_ram
  import grid_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [1:0] wdata,
  output logic [1:0] rdata
);
  cell_t mem [NUM_CELLS];
  assign rdata = mem[addr];
  // One write per cycle; the arbiter registers whatever it reads
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/grid_mem_arbiter.sv
// grid_mem_arbiter: slot-based sharing of the grid memory between display and game
module grid_mem_arbiter
  import grid_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic       disp_phase,
  input  logic       disp_active,
  input  logic [3:0] disp_x,
  input  logic [3:0] disp_y,
  output logic [1:0] disp_data,
  input  logic       clear,
  output logic       init_busy,
  input  logic       gm_req,
  input  logic       gm_we,
  input  logic [3:0] gm_x,
  input  logic [3:0] gm_y,
  input  logic [1:0] gm_wdata,
  output logic       gm_ack,
  output logic [1:0] gm_rdata,
  output logic       gm_err
);
  state_t state;
  addr_t  cnt;
  logic   run, disp_ok, gm_ok, disp_rd, gm_grant, ram_we;
  addr_t  ram_addr;
  cell_t  ram_wdata, ram_rdata;

  grid_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Slot decode: a cycle that samples clear grants nothing so no ack lands inside the sweep
  always_comb begin
    run       = (state == S_RUN) && !clear;
    disp_ok   = in_grid(disp_x, disp_y);
    gm_ok     = in_grid(gm_x, gm_y);
    disp_rd   = run && !disp_phase && disp_active;
    gm_grant  = run && gm_req && !gm_ack && (disp_phase || !disp_active);
    ram_addr  = (state == S_INIT) ? cnt : disp_rd ? cell_addr(disp_x, disp_y) : cell_addr(gm_x, gm_y);
    ram_we    = (state == S_INIT) || (gm_grant && gm_we && gm_ok);
    ram_wdata = (state == S_INIT) ? INIT_CELL : gm_wdata;
  end

  // Sweep/run state machine with registered display and game responses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_INIT;
      cnt        <= '0;
      init_busy  <= 1'b1;
      disp_phase <= 1'b0;
      disp_data  <= CELL_WORLD;
      gm_ack     <= 1'b0;
      gm_rdata   <= CELL_WORLD;
      gm_err     <= 1'b0;
    end else begin
      disp_phase <= ~disp_phase;
      disp_data  <= disp_rd ? (disp_ok ? ram_rdata : CELL_WORLD) : (run && disp_phase) ? disp_data : CELL_WORLD;
      gm_ack     <= gm_grant;
      gm_err     <= gm_grant && !gm_ok;
      gm_rdata   <= (gm_grant && !gm_we && gm_ok) ? ram_rdata : CELL_WORLD;
      if (state == S_INIT) begin
        cnt <= (cnt == addr_t'(NUM_CELLS - 1)) ? '0 : cnt + 8'd1;
        if (cnt == addr_t'(NUM_CELLS - 1)) begin
          state     <= S_RUN;
          init_busy <= 1'b0;
        end
      end else if (clear) begin
        state     <= S_INIT;
        cnt       <= '0;
        init_busy <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_grid_mem_arbiter.sv
// tb_grid_mem_arbiter: directed scenario tests for the grid memory arbiter
module tb_grid_mem_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       disp_phase;
  logic       disp_active = 1'b0;
  logic [3:0] disp_x = '0;
  logic [3:0] disp_y = '0;
  logic [1:0] disp_data;
  logic       clear = 1'b0;
  logic       init_busy;
  logic       gm_req = 1'b0;
  logic       gm_we = 1'b0;
  logic [3:0] gm_x = '0;
  logic [3:0] gm_y = '0;
  logic [1:0] gm_wdata = '0;
  logic       gm_ack;
  logic [1:0] gm_rdata;
  logic       gm_err;
  int         checks = 0;
  int         failures = 0;
  logic       exp_phase = 1'b0;

  grid_mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .disp_phase  (disp_phase),
    .disp_active (disp_active),
    .disp_x      (disp_x),
    .disp_y      (disp_y),
    .disp_data   (disp_data),
    .clear       (clear),
    .init_busy   (init_busy),
    .gm_req      (gm_req),
    .gm_we       (gm_we),
    .gm_x        (gm_x),
    .gm_y        (gm_y),
    .gm_wdata    (gm_wdata),
    .gm_ack      (gm_ack),
    .gm_rdata    (gm_rdata),
    .gm_err      (gm_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    if (reset) exp_phase = ~exp_phase;
  endtask

  task automatic sync_phase0;
    while (exp_phase !== 1'b0) tick;
  endtask

  task automatic gm_access(input logic we, input logic [3:0] x, input logic [3:0] y, input logic [1:0] wd,
                           output logic [1:0] rd, output logic err, output int lat);
    logic acked;
    gm_req = 1'b1; gm_we = we; gm_x = x; gm_y = y; gm_wdata = wd; lat = 0;
    do begin
      tick;
      lat++;
    end while (gm_ack !== 1'b1 && lat < 20);
    acked = gm_ack; rd = gm_rdata; err = gm_err;
    gm_req = 1'b0;
    checks++;
    if (acked !== 1'b1) begin
      failures++;
      $display("FAIL gm_ack_timeout x=%0d y=%0d got=%b exp=1", x, y, acked);
    end
    tick;
  endtask

  task automatic wait_sweep(output int n, output int acks, output int dirty);
    n = 0; acks = 0; dirty = 0;
    while (init_busy === 1'b1 && n < 1000) begin
      n++;
      if (gm_ack !== 1'b0) acks++;
      if (disp_data !== 2'b00) dirty++;
      tick;
    end
  endtask

  task automatic test_reset;
    int n, acks, dirty, k;
    #12;
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL rst_init_busy got=%b exp=1", init_busy); end
    checks++; if (disp_phase !== 1'b0) begin failures++; $display("FAIL rst_disp_phase got=%b exp=0", disp_phase); end
    checks++; if (disp_data !== 2'b00) begin failures++; $display("FAIL rst_disp_data got=%b exp=00", disp_data); end
    checks++; if ({gm_ack, gm_err, gm_rdata} !== 4'b0000) begin failures++; $display("FAIL rst_gm_outputs got=%b exp=0000", {gm_ack, gm_err, gm_rdata}); end
    @(posedge clk); #1;
    reset = 1'b1; exp_phase = 1'b0;
    gm_req = 1'b1; gm_we = 1'b0; gm_x = 4'd3; gm_y = 4'd4;
    wait_sweep(n, acks, dirty);
    checks++; if (n !== 225) begin failures++; $display("FAIL rst_sweep_len got=%0d exp=225", n); end
    checks++; if (acks !== 0) begin failures++; $display("FAIL rst_ack_in_sweep got=%0d exp=0", acks); end
    checks++; if (dirty !== 0) begin failures++; $display("FAIL rst_disp_in_sweep got=%0d exp=0", dirty); end
    k = 0;
    while (gm_ack !== 1'b1 && k < 10) begin tick; k++; end
    checks++; if (k !== 1) begin failures++; $display("FAIL rst_req_ack_lat got=%0d exp=1", k); end
    checks++; if ({gm_err, gm_rdata} !== 3'b000) begin failures++; $display("FAIL rst_read_3_4 got=%b exp=000", {gm_err, gm_rdata}); end
    gm_req = 1'b0;
    tick;
    checks++; if (disp_phase !== exp_phase) begin failures++; $display("FAIL phase_track got=%b exp=%b", disp_phase, exp_phase); end
  endtask

  task automatic test_write_display;
    logic [1:0] rd; logic err; int lat;
    gm_access(1'b1, 4'd5, 4'd7, 2'b10, rd, err, lat);
    checks++; if ({err, rd} !== 3'b000) begin failures++; $display("FAIL wr_5_7_resp got=%b exp=000", {err, rd}); end
    gm_access(1'b1, 4'd0, 4'd7, 2'b01, rd, err, lat);
    sync_phase0;
    disp_active = 1'b1; disp_x = 4'd5; disp_y = 4'd7;
    tick;
    checks++; if (disp_data !== 2'b10) begin failures++; $display("FAIL disp_5_7 got=%b exp=10", disp_data); end
    checks++; if (disp_phase !== 1'b1) begin failures++; $display("FAIL disp_phase1 got=%b exp=1", disp_phase); end
    disp_x = 4'd6;
    tick;
    checks++; if (disp_data !== 2'b10) begin failures++; $display("FAIL disp_hold got=%b exp=10", disp_data); end
    tick;
    checks++; if (disp_data !== 2'b00) begin failures++; $display("FAIL disp_6_7 got=%b exp=00", disp_data); end
    disp_x = 4'd15; disp_y = 4'd6;
    tick; tick;
    checks++; if (disp_data !== 2'b00) begin failures++; $display("FAIL disp_oor got=%b exp=00", disp_data); end
    disp_x = 4'd0; disp_y = 4'd7;
    tick; tick;
    checks++; if (disp_data !== 2'b01) begin failures++; $display("FAIL disp_0_7 got=%b exp=01", disp_data); end
    disp_active = 1'b0;
    tick; tick;
    checks++; if (disp_data !== 2'b00) begin failures++; $display("FAIL disp_blank got=%b exp=00", disp_data); end
    disp_x = 4'd5;
  endtask

  task automatic test_latency;
    logic [1:0] rd; logic err; int lat;
    sync_phase0;
    disp_active = 1'b1;
    gm_access(1'b0, 4'd5, 4'd7, 2'b00, rd, err, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL lat_active got=%0d exp=2", lat); end
    checks++; if (rd !== 2'b10) begin failures++; $display("FAIL lat_active_data got=%b exp=10", rd); end
    disp_active = 1'b0;
    gm_access(1'b0, 4'd5, 4'd7, 2'b00, rd, err, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL lat_blank got=%0d exp=1", lat); end
    checks++; if (rd !== 2'b10) begin failures++; $display("FAIL lat_blank_data got=%b exp=10", rd); end
  endtask

  task automatic test_err;
    logic [1:0] rd; logic err; int lat;
    gm_access(1'b1, 4'd0, 4'd3, 2'b10, rd, err, lat);
    gm_access(1'b0, 4'd15, 4'd2, 2'b00, rd, err, lat);
    checks++; if ({err, rd} !== 3'b100) begin failures++; $display("FAIL err_rd_15_2 got=%b exp=100", {err, rd}); end
    gm_access(1'b1, 4'd15, 4'd2, 2'b01, rd, err, lat);
    checks++; if ({err, rd} !== 3'b100) begin failures++; $display("FAIL err_wr_15_2 got=%b exp=100", {err, rd}); end
    gm_access(1'b0, 4'd3, 4'd15, 2'b00, rd, err, lat);
    checks++; if ({err, rd} !== 3'b100) begin failures++; $display("FAIL err_rd_3_15 got=%b exp=100", {err, rd}); end
    gm_access(1'b0, 4'd0, 4'd3, 2'b00, rd, err, lat);
    checks++; if ({err, rd} !== 3'b010) begin failures++; $display("FAIL err_mem_unchanged got=%b exp=010", {err, rd}); end
  endtask

  task automatic test_clear;
    logic [1:0] rd; logic err; int lat, n, dirty;
    gm_access(1'b1, 4'd0, 4'd0, 2'b01, rd, err, lat);
    gm_access(1'b1, 4'd14, 4'd14, 2'b10, rd, err, lat);
    gm_access(1'b0, 4'd14, 4'd14, 2'b00, rd, err, lat);
    checks++; if (rd !== 2'b10) begin failures++; $display("FAIL clr_pre_14_14 got=%b exp=10", rd); end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    n = 0; dirty = 0;
    while (init_busy === 1'b1 && n < 1000) begin
      n++;
      if (disp_data !== 2'b00) dirty++;
      clear = (n == 50);
      tick;
    end
    clear = 1'b0;
    checks++; if (n !== 225) begin failures++; $display("FAIL clr_sweep_len got=%0d exp=225", n); end
    checks++; if (dirty !== 0) begin failures++; $display("FAIL clr_disp_in_sweep got=%0d exp=0", dirty); end
    gm_access(1'b0, 4'd0, 4'd0, 2'b00, rd, err, lat);
    checks++; if ({err, rd} !== 3'b000) begin failures++; $display("FAIL clr_0_0 got=%b exp=000", {err, rd}); end
    gm_access(1'b0, 4'd14, 4'd14, 2'b00, rd, err, lat);
    checks++; if ({err, rd} !== 3'b000) begin failures++; $display("FAIL clr_14_14 got=%b exp=000", {err, rd}); end
    gm_access(1'b0, 4'd5, 4'd7, 2'b00, rd, err, lat);
    checks++; if (rd !== 2'b00) begin failures++; $display("FAIL clr_5_7 got=%b exp=00", rd); end
  endtask

  task automatic test_reset_mid;
    logic [1:0] rd; logic err; int lat, n, acks, dirty;
    gm_access(1'b1, 4'd14, 4'd14, 2'b10, rd, err, lat);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    repeat (100) tick;
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL mid_busy_at_100 got=%b exp=1", init_busy); end
    #2;
    reset = 1'b0; exp_phase = 1'b0;
    #1;
    checks++; if ({init_busy, disp_phase, disp_data} !== 4'b1000) begin failures++; $display("FAIL mid_rst_vals got=%b exp=1000", {init_busy, disp_phase, disp_data}); end
    tick; tick;
    reset = 1'b1;
    wait_sweep(n, acks, dirty);
    checks++; if (n !== 225) begin failures++; $display("FAIL mid_restart_len got=%0d exp=225", n); end
    disp_active = 1'b0;
    gm_req = 1'b1; gm_we = 1'b0; gm_x = 4'd14; gm_y = 4'd14;
    #2;
    reset = 1'b0; exp_phase = 1'b0; gm_req = 1'b0;
    #1;
    checks++; if (gm_ack !== 1'b0) begin failures++; $display("FAIL abandon_ack_now got=%b exp=0", gm_ack); end
    tick; tick;
    checks++; if ({gm_ack, gm_err, gm_rdata} !== 4'b0000) begin failures++; $display("FAIL abandon_ack_held got=%b exp=0000", {gm_ack, gm_err, gm_rdata}); end
    reset = 1'b1;
    wait_sweep(n, acks, dirty);
    checks++; if (n !== 225) begin failures++; $display("FAIL abandon_sweep_len got=%0d exp=225", n); end
    checks++; if (acks !== 0) begin failures++; $display("FAIL abandon_late_ack got=%0d exp=0", acks); end
    gm_access(1'b0, 4'd14, 4'd14, 2'b00, rd, err, lat);
    checks++; if ({err, rd} !== 3'b000) begin failures++; $display("FAIL mid_14_14_cleared got=%b exp=000", {err, rd}); end
  endtask

  initial begin
    test_reset;
    test_write_display;
    test_latency;
    test_err;
    test_clear;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/grid_mem_arbiter.md
# grid_mem_arbiter

Owns the 15x15 game-grid cell memory and arbitrates its single port between the VGA display path and the snake game logic. Display reads get a fixed time slot on every other `clk` cycle, aligned to the clk/2 pixel clock. The game port uses the opposite slot, or both slots during blanking. After reset, and on request, the block sweeps the whole grid to the world value before granting any access.

## Interface
- `GRID_W`, 15, grid columns
- `GRID_H`, 15, grid rows
- `CELL_BITS`, 2, cell width (00 world, 01 food, 10 snake)
- `INIT_CELL`, 2'b00, value written by the clear sweep

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `reset` in 1: asynchronous, active-low
- `disp_phase` out 1: slot phase; 0 = display slot, 1 = game slot
- `disp_active` in 1: display is in active video
- `disp_x`, `disp_y` in 4 each: cell coordinate being displayed
- `disp_data` out 2: registered cell value for the display
- `clear` in 1: one-cycle pulse requesting a grid re-initialisation
- `init_busy` out 1: clear sweep in progress
- `gm_req` in 1: game access request, held until `gm_ack`
- `gm_we` in 1: 1 = write, 0 = read
- `gm_x`, `gm_y` in 4 each: game access coordinate
- `gm_wdata` in 2: write data
- `gm_ack` out 1: one-cycle completion pulse
- `gm_rdata` out 2: read data, valid with `gm_ack`
- `gm_err` out 1: coordinate out of range, valid with `gm_ack`

## Operation
- Address = y*GRID_W + x, 8 bits, range 0..224.
- Out of range: x ≥ GRID_W or y ≥ GRID_H.
- `disp_phase` toggles every `clk` cycle.
- States:
  - S_INIT: counter 0..224 writes `INIT_CELL` to one cell per cycle. Display reads are not performed and `disp_data` = 00. Game requests are held off (no ack). After writing 224, go to S_RUN.
  - S_RUN: normal arbitration.
  - `clear` sampled high in S_RUN: next cycle enters S_INIT with the counter at 0.
  - `clear` during S_INIT is ignored.
- Display slot (S_RUN, `disp_phase`=0, `disp_active`=1):
  - Memory read at the display address; `disp_data` updated next cycle.
  - Out-of-range coordinate gives 00.
- `disp_active`=0 sampled at phase 0: `disp_data` ← 00.
- `disp_data` is held on phase-1 cycles.
- Game slot: S_RUN, `gm_req`=1, `gm_ack`=0, and (`disp_phase`=1 or `disp_active`=0).
  - Write: memory write.
  - Read: memory read.
  - Next cycle: `gm_ack`=1; `gm_rdata` = read value (00 for writes).
  - Out-of-range coordinate: no memory access, `gm_err`=1, `gm_rdata`=00, ack still given.
- Handshake rules:
  - `gm_req` sampled while `gm_ack`=1 is ignored, giving a one-cycle bubble.
  - Requester keeps `gm_we`, `gm_x`, `gm_y`, `gm_wdata` stable from request until ack.
  - The requester drops `gm_req` or presents a new request in the ack cycle.
- Same-address display read and game write fall in different slots, so there is no conflict. The read returns the value before or after the write according to slot order.

## Timing
- Reset values:
  - `disp_phase`=0, `disp_data`=00
  - `init_busy`=1, state S_INIT, counter 0
  - `gm_ack`=0, `gm_rdata`=00, `gm_err`=0
- Clear sweep: `init_busy` stays high for exactly 225 cycles after reset release or after the cycle following `clear`.
- Display latency: address sampled in phase-0 cycle N; `disp_data` valid at N+1 and stable through N+2.
- Game latency:
  - ack 1 cycle after grant.
  - Grant at most 1 cycle after request in S_RUN during active video.
  - Grant in the same cycle during blanking.
- Reset asserted mid-sweep or mid-access:
  - The in-flight access is abandoned with no ack.
  - The sweep restarts from 0 after release.

## Structure
- Package `grid_pkg`:
  - `GRID_W`, `GRID_H`, `NUM_CELLS`=225
  - `cell_t` (2-bit)
  - `CELL_WORLD`/`CELL_FOOD`/`CELL_SNAKE`
  - `coord_t` (4-bit), `addr_t` (8-bit)
  - State enum
- Sub-module `grid_ram`: single-port synchronous RAM, 225x2, one read or write per cycle. The arbiter drives its address, write enable and data mux.

## Test plan
- Reset release: `init_busy` high for 225 cycles. A `gm_req` read at (3,4) issued during the sweep is acked only after the sweep and returns 00.
- Write (5,7)=10, then display at (5,7) during active video: `disp_data`=10 the cycle after phase 0; (6,7) gives 00.
- `gm_req` asserted at phase 0 with `disp_active`=1: grant on phase 1, ack 2 cycles after request. Same request with `disp_active`=0: ack 1 cycle after request.
- Game read at (15,2): `gm_ack`=1, `gm_err`=1, `gm_rdata`=00, memory unchanged.
- Fill (0,0)=01 and (14,14)=10, pulse `clear`: 225-cycle sweep, then both cells read 00.
- Assert reset at sweep count 100: outputs return to reset values immediately, and the sweep restarts at 0 after release.
